// File: rtl/display_pkg.sv
// Shared definitions for the seven-segment display arbiter and its scheduler.
package display_pkg;

  localparam int unsigned DISP_NREQ_DEFAULT  = 4;
  localparam logic [31:0] DISP_DWELL_DEFAULT = 32'd99_999_999;

  typedef enum logic {
    IDLE = 1'b0,
    SHOW = 1'b1
  } disp_state_t;

endpackage

// File: rtl/display_rr_pick.sv
// Combinational winner selection: fixed priority (lowest index) or round-robin after 'last'.
module display_rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned SW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] pending,
  input  logic [SW-1:0]   last,
  input  logic            mode,
  output logic            any,
  output logic [SW-1:0]   winner
);

  int unsigned     idx;
  logic [SW-1:0]   sel;
  logic            found;

  // Scan NREQ candidates in order; round-robin starts one past the last grant and wraps.
  always_comb begin
    any    = |pending;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    sel    = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = mode ? ((32'(last) + k + 1) % NREQ) : k;
      sel = SW'(idx);
      if (!found && pending[sel]) begin
        found  = 1'b1;
        winner = sel;
      end
    end
  end

endmodule

// File: rtl/display_arbiter.sv
// Shares one 8-digit display between NREQ word sources: one-entry buffers, scheduler, dwell timer.
module display_arbiter
  import display_pkg::*;
#(
  parameter int unsigned NREQ  = DISP_NREQ_DEFAULT,
  parameter logic [31:0] DWELL = DISP_DWELL_DEFAULT,
  parameter int unsigned SW    = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mode,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [32*NREQ-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  output logic [31:0]        out_data,
  output logic               out_en,
  output logic [SW-1:0]      cur_src,
  output logic               busy
);

  disp_state_t     state;
  logic [31:0]     cnt;
  logic [NREQ-1:0] pending;
  logic [31:0]     word_buf [NREQ];
  logic [SW-1:0]   last;

  logic            any;
  logic [SW-1:0]   winner;
  logic [NREQ-1:0] accept;
  logic [NREQ-1:0] clr;
  logic            refresh;

  display_rr_pick #(
    .NREQ (NREQ),
    .SW   (SW)
  ) u_pick (
    .pending (pending),
    .last    (last),
    .mode    (mode),
    .any     (any),
    .winner  (winner)
  );

  assign req_ready = ~pending & {NREQ{~rst}};
  assign busy      = (state == SHOW);
  assign accept    = req_valid & ~pending;
  assign refresh   = (state == SHOW) && pending[cur_src];

  // Accepts only touch non-pending slots, so set and clear never hit the same bit.
  always_comb begin
    clr = '0;
    if (state == IDLE && any) clr[winner]  = 1'b1;
    else if (refresh)         clr[cur_src] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      pending  <= '0;
      out_data <= '0;
      out_en   <= 1'b0;
      cur_src  <= '0;
      last     <= SW'(NREQ - 1);
      for (int unsigned i = 0; i < NREQ; i++) word_buf[i] <= '0;
    end else begin
      out_en  <= 1'b0;
      pending <= (pending | accept) & ~clr;
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (accept[i]) word_buf[i] <= req_data[32*i +: 32];
      end
      case (state)
        IDLE: begin
          if (any) begin
            out_data <= word_buf[winner];
            out_en   <= 1'b1;
            cur_src  <= winner;
            last     <= winner;
            cnt      <= DWELL;
            state    <= SHOW;
          end
        end
        SHOW: begin
          if (refresh) begin
            out_data <= word_buf[cur_src];
            out_en   <= 1'b1;
          end
          if (cnt == '0) begin
            state <= IDLE;
          end else begin
            cnt <= cnt - 32'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_display_arbiter.sv
// Self-checking bench for display_arbiter: reference model compared every cycle plus directed scenarios.
module tb_display_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         mode = 1'b0;
  logic [3:0]   req_valid = '0;
  logic [127:0] req_data = '0;
  logic [3:0]   req_ready;
  logic [31:0]  out_data;
  logic         out_en;
  logic [1:0]   cur_src;
  logic         busy;

  display_arbiter #(
    .NREQ  (NREQ),
    .DWELL (32'(DW)),
    .SW    (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_data  (out_data),
    .out_en    (out_en),
    .cur_src   (cur_src),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: what the display must show, in terms of buffered words and remaining dwell.
  bit          m_pend [4] = '{0, 0, 0, 0};
  logic [31:0] m_buf  [4] = '{32'h0, 32'h0, 32'h0, 32'h0};
  bit          np     [4];
  bit          m_show = 0;
  int          m_rem = 0;
  int          m_last = NREQ - 1;
  logic [31:0] m_od = '0;
  bit          m_oe = 0;
  int          m_cs = 0;
  int          w;

  function automatic int pick(input bit rr, input int lst);
    for (int k = 1; k <= NREQ; k++) begin
      int idx;
      idx = rr ? (lst + k) % NREQ : k - 1;
      if (m_pend[idx]) return idx;
    end
    return -1;
  endfunction

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      for (int i = 0; i < NREQ; i++) begin m_pend[i] = 0; m_buf[i] = '0; end
      m_show = 0; m_rem = 0; m_last = NREQ - 1; m_od = '0; m_oe = 0; m_cs = 0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        np[i] = m_pend[i];
        if (req_valid[i] && !m_pend[i]) begin
          np[i] = 1;
          m_buf[i] = req_data[32*i +: 32];
        end
      end
      m_oe = 0;
      if (!m_show) begin
        w = pick(mode, m_last);
        if (w >= 0) begin
          m_od = m_buf[w]; m_oe = 1; m_cs = w; m_last = w; np[w] = 0;
          m_show = 1; m_rem = DW;
        end
      end else begin
        if (m_pend[m_cs]) begin
          m_od = m_buf[m_cs]; m_oe = 1; np[m_cs] = 0;
        end
        if (m_rem == 0) m_show = 0;
        else m_rem = m_rem - 1;
      end
      for (int i = 0; i < NREQ; i++) m_pend[i] = np[i];
    end
  end

  // Per-cycle comparison and strobe log.
  int          log_src[$];
  logic [31:0] log_data[$];
  int          log_cyc[$];
  int          run = 0;
  int          show_len = 0;
  logic [3:0]  er;

  initial forever begin
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) er[i] = !rst && !m_pend[i];
    check("cycle_outputs",
          64'({out_data, out_en, cur_src, busy, req_ready}),
          64'({m_od, m_oe, 2'(m_cs), m_show, er}));
    if (out_en) begin
      log_src.push_back(int'(cur_src));
      log_data.push_back(out_data);
      log_cyc.push_back(cyc);
    end
    if (busy) run++;
    else if (run > 0) begin show_len = run; run = 0; end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_log();
    log_src.delete(); log_data.delete(); log_cyc.delete();
  endtask

  task automatic wait_log(input int n, input int budget);
    for (int i = 0; i < budget && log_src.size() < n; i++) @(posedge clk);
    #2;
    if (log_src.size() < n) begin
      errors++;
      $display("FAIL wait_log timeout actual %0d strobes required %0d", log_src.size(), n);
    end
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 50 && busy; i++) step();
    if (busy) begin
      errors++;
      $display("FAIL wait_idle timeout actual busy=1 required busy=0");
    end
  endtask

  task automatic expect_log(input string name, input int k, input int src, input logic [31:0] data);
    if (k >= log_src.size()) begin
      checks++; errors++;
      $display("FAIL %s missing strobe actual %0d entries required index %0d", name, log_src.size(), k);
    end else begin
      check({name, "_src"}, 64'(log_src[k]), 64'(src));
      check({name, "_data"}, 64'(log_data[k]), 64'(data));
    end
  endtask

  initial begin
    #1 rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 64'(req_ready), 64'h0f);
    check("busy_after_rst", 64'(busy), 64'h0);

    // Single request
    step(); clear_log();
    req_valid = 4'b0100; req_data[95:64] = 32'h1234_5678;
    step(); req_valid = '0;
    @(negedge clk);
    check("single_ready_low", 64'(req_ready), 64'h0b);
    check("single_no_strobe_yet", 64'(out_en), 64'h0);
    @(negedge clk);
    check("single_strobe", 64'(out_en), 64'h1);
    check("single_data", 64'(out_data), 64'h1234_5678);
    check("single_src", 64'(cur_src), 64'h2);
    check("single_ready_back", 64'(req_ready), 64'h0f);
    step(); wait_idle();

    // Fixed priority: all four at once
    mode = 1'b0; clear_log();
    req_valid = 4'hf;
    for (int i = 0; i < NREQ; i++) req_data[32*i +: 32] = 32'h0000_00A0 + 32'(i);
    step(); req_valid = '0;
    wait_log(4, 60);
    for (int i = 0; i < NREQ; i++) begin
      expect_log("prio", i, i, 32'h0000_00A0 + 32'(i));
      if (i > 0 && i < log_cyc.size()) check("prio_spacing", 64'(log_cyc[i] - log_cyc[i-1]), 64'(DW + 2));
    end
    wait_idle();

    // Round-robin with wrap-around
    mode = 1'b1; clear_log();
    req_valid = 4'b0010; req_data[63:32] = 32'h0000_0011;
    step(); req_valid = '0;
    wait_log(1, 20);
    req_valid = 4'b1001; req_data[31:0] = 32'h0000_0000; req_data[127:96] = 32'h0000_0033;
    step(); req_valid = '0;
    wait_log(3, 40);
    expect_log("rr0", 0, 1, 32'h0000_0011);
    expect_log("rr1", 1, 3, 32'h0000_0033);
    expect_log("rr2", 2, 0, 32'h0000_0000);
    wait_idle();

    // Refresh during SHOW; dwell length unchanged
    mode = 1'b0; clear_log();
    req_valid = 4'b0010; req_data[63:32] = 32'h1111_1111;
    step(); req_valid = '0;
    wait_log(1, 20);
    req_valid = 4'b0010; req_data[63:32] = 32'h0000_BEEF;
    step(); req_valid = '0;
    wait_log(2, 20);
    expect_log("refresh", 1, 1, 32'h0000_BEEF);
    if (log_cyc.size() >= 2) check("refresh_delay", 64'(log_cyc[1] - log_cyc[0]), 64'h3);
    wait_idle(); step();
    check("refresh_show_len", 64'(show_len), 64'(DW + 1));

    // Back-pressure: held valid must not overwrite the pending word
    clear_log();
    req_valid = 4'b1000; req_data[127:96] = 32'h0000_00D3;
    step();
    req_valid = 4'b0001; req_data[31:0] = 32'h0000_AAAA;
    step();
    req_data[31:0] = 32'h0000_BBBB;
    @(negedge clk);
    check("bp_ready0_low", 64'(req_ready[0]), 64'h0);
    check("bp_busy", 64'(busy), 64'h1);
    wait_log(2, 20);
    req_valid = '0;
    wait_log(3, 20);
    expect_log("bp0", 0, 3, 32'h0000_00D3);
    expect_log("bp1", 1, 0, 32'h0000_AAAA);
    expect_log("bp2", 2, 0, 32'h0000_BBBB);
    wait_idle();

    // Reset mid-SHOW discards pending words
    clear_log();
    req_valid = 4'b0100; req_data[95:64] = 32'h0000_CAFE;
    step(); req_valid = '0;
    wait_log(1, 20);
    req_valid = 4'b0010; req_data[63:32] = 32'h0000_0077;
    step(); req_valid = '0;
    rst = 1'b1;
    @(negedge clk);
    check("rst_out_data", 64'(out_data), 64'h0);
    check("rst_out_en", 64'(out_en), 64'h0);
    check("rst_cur_src", 64'(cur_src), 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_ready", 64'(req_ready), 64'h0);
    step(); rst = 1'b0;
    @(negedge clk);
    check("rst_release_ready", 64'(req_ready), 64'h0f);
    repeat (10) step();
    check("rst_discard", 64'(log_src.size()), 64'h1);

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      step();
      mode = 1'($urandom);
      req_valid = 4'($urandom) & 4'($urandom);
      for (int i = 0; i < NREQ; i++) req_data[32*i +: 32] = $urandom;
      rst = ($urandom_range(0, 59) == 0);
    end
    step(); rst = 1'b0; req_valid = '0;
    repeat (20) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual timeout required completion");
    $fatal(1, "watchdog");
  end

endmodule
